// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers: occupancy count type, operation encoding, depth derivation.
package fifo_pkg;

  localparam int DefAddrWidth = 4;

  typedef logic [DefAddrWidth:0] fifo_cnt_t;

  // Encoding is {pop, push} so the accepted pair can be cast directly.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int calc_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sa_fifo_regfile.sv
// One-write, one-asynchronous-read register array backing the show-ahead FIFO.
module sa_fifo_regfile
  import fifo_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 wen_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int Depth = calc_depth(AddrWidth);

  // Storage is intentionally not reset; the pointers define what is valid.
  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sa_sc_fifo_flags.sv
// Show-ahead single-clock FIFO with occupancy count, almost-full/empty thresholds
// and sticky overflow/underflow flags.
module sa_sc_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclr,
  input  logic                 we,
  input  logic [DataWidth-1:0] d,
  input  logic                 ack,
  output logic [DataWidth-1:0] q,
  output logic                 empty,
  output logic                 full,
  output logic [AddrWidth:0]   usedw,
  input  logic [AddrWidth:0]   af_thr,
  input  logic [AddrWidth:0]   ae_thr,
  output logic                 almost_full,
  output logic                 almost_empty,
  input  logic                 err_clr,
  output logic                 ovf,
  output logic                 udf
);

  localparam int Depth = calc_depth(AddrWidth);
  localparam logic [AddrWidth:0] DepthCnt = (AddrWidth+1)'(Depth);
  localparam logic [AddrWidth:0] OneCnt   = (AddrWidth+1)'(1);
  localparam logic [AddrWidth-1:0] OnePtr = AddrWidth'(1);

  logic [AddrWidth-1:0] wp_q, wp_d;
  logic [AddrWidth-1:0] rp_q, rp_d;
  logic [AddrWidth:0]   usedw_q, usedw_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic     push, pop, mem_wen;
  logic     ovf_set, udf_set;
  fifo_op_e op;

  assign empty = (usedw_q == '0);
  assign full  = (usedw_q == DepthCnt);

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign push    = we && (!full || ack);
  assign pop     = ack && !empty;
  assign ovf_set = we && full && !ack;
  assign udf_set = ack && empty;
  assign mem_wen = push && rst_n && !sclr;

  always_comb begin
    op      = fifo_op_e'({pop, push});
    wp_d    = wp_q;
    rp_d    = rp_q;
    usedw_d = usedw_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (sclr) begin
      wp_d    = '0;
      rp_d    = '0;
      usedw_d = '0;
      if (err_clr) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
    end else begin
      if (push) wp_d = wp_q + OnePtr;
      if (pop)  rp_d = rp_q + OnePtr;
      unique case (op)
        OP_PUSH: usedw_d = usedw_q + OneCnt;
        OP_POP:  usedw_d = usedw_q - OneCnt;
        default: usedw_d = usedw_q;
      endcase
      // A fresh error in the clearing cycle wins over err_clr.
      ovf_d = ovf_set || (ovf_q && !err_clr);
      udf_d = udf_set || (udf_q && !err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      usedw_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      usedw_q <= usedw_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  sa_fifo_regfile #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth)
  ) u_regfile (
    .clk    (clk),
    .wen_i  (mem_wen),
    .waddr_i(wp_q),
    .wdata_i(d),
    .raddr_i(rp_q),
    .rdata_o(q)
  );

  assign usedw        = usedw_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;
  assign almost_full  = (usedw_q >= af_thr);
  assign almost_empty = (usedw_q <= ae_thr);

endmodule

// File: tb/tb_sa_sc_fifo_flags.sv
// Self-checking bench for sa_sc_fifo_flags: behavioural model plus data scoreboard queue.
module tb_sa_sc_fifo_flags;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n, sclr, we, ack, err_clr;
  logic [DW-1:0] d;
  logic [DW-1:0] q;
  logic          empty, full, almost_full, almost_empty, ovf, udf;
  logic [AW:0]   usedw, af_thr, ae_thr;

  int n_tests = 0;
  int n_fail  = 0;

  int            m_cnt = 0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  sa_sc_fifo_flags #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .we(we), .d(d), .ack(ack), .q(q),
    .empty(empty), .full(full), .usedw(usedw), .af_thr(af_thr), .ae_thr(ae_thr),
    .almost_full(almost_full), .almost_empty(almost_empty), .err_clr(err_clr),
    .ovf(ovf), .udf(udf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("usedw", 32'(usedw), 32'(m_cnt));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("full", 32'(full), 32'(m_cnt == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(m_cnt >= int'(af_thr)));
    chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= int'(ae_thr)));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
    if (m_cnt != 0) chk("q_head", 32'(q), 32'(sb[0]));
  endtask

  // Drive one cycle, advance the model across the edge, then check all outputs.
  task automatic step(input logic rv, input logic sv, input logic wv,
                      input logic [DW-1:0] dv, input logic av, input logic cv);
    logic mfull, mempty, mpush, mpop;
    rst_n = rv; sclr = sv; we = wv; d = dv; ack = av; err_clr = cv;
    mfull  = (m_cnt == DEPTH);
    mempty = (m_cnt == 0);
    if (!rv) begin
      m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0; sb.delete();
    end else if (sv) begin
      m_cnt = 0; sb.delete();
      if (cv) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      mpush = wv && (!mfull || av);
      mpop  = av && !mempty;
      if (mpop) begin
        chk("q_popped", 32'(q), 32'(sb[0]));
        void'(sb.pop_front());
      end
      if (mpush) sb.push_back(dv);
      m_cnt = m_cnt + int'(mpush) - int'(mpop);
      m_ovf = (wv && mfull && !av) || (m_ovf && !cv);
      m_udf = (av && mempty) || (m_udf && !cv);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; sclr = 1'b0; we = 1'b0; ack = 1'b0; err_clr = 1'b0;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; sclr = 1'b0; we = 1'b0; ack = 1'b0; err_clr = 1'b0; d = '0;
    af_thr = 5'd12; ae_thr = 5'd2;

    step(0, 0, 0, 8'h00, 0, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);

    // Fill with 0x01..0x10.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, 1, 8'(i), 0, 0);
      chk("fill_q", 32'(q), 32'h01);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_af", 32'(almost_full), 32'd1);

    // Overflow, then simultaneous write+ack while full, then clear.
    step(1, 0, 1, 8'hAA, 0, 0);
    chk("ovf_set", 32'(ovf), 32'd1);
    step(1, 0, 1, 8'hBB, 1, 0);
    chk("full_both_q", 32'(q), 32'h02);
    chk("full_both_usedw", 32'(usedw), 32'd16);
    step(1, 0, 0, 8'h00, 0, 1);
    chk("ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'h00, 1, 0);
    chk("drain_tail_seen", 32'(empty), 32'd1);

    // Write+ack on empty: push accepted, pop rejected.
    step(1, 0, 1, 8'h5C, 1, 0);
    chk("empty_both_udf", 32'(udf), 32'd1);
    chk("empty_both_q", 32'(q), 32'h5C);
    step(1, 0, 0, 8'h00, 1, 1);
    chk("empty_after_ack", 32'(empty), 32'd1);

    // Alternating push/pop across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) step(1, 0, 1, 8'(8'h30 + i), 0, 0);
      else            step(1, 0, 0, 8'h00, 1, 0);
    end

    // sclr overrides we/ack at usedw=7.
    for (int i = 0; i < 7; i++) step(1, 0, 1, 8'(8'h70 + i), 0, 0);
    step(1, 1, 1, 8'hEE, 1, 0);
    chk("sclr_usedw", 32'(usedw), 32'd0);
    chk("sclr_no_err", 32'({ovf, udf}), 32'd0);

    // Reset clears a pending overflow.
    for (int i = 0; i <= DEPTH; i++) step(1, 0, 1, 8'(i), 0, 0);
    chk("pre_rst_ovf", 32'(ovf), 32'd1);
    step(0, 0, 0, 8'h00, 0, 0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Live threshold changes.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 8'(8'h90 + i), 0, 0);
    chk("af_thr12", 32'(almost_full), 32'd0);
    af_thr = 5'd3; #1;
    chk("af_thr3_comb", 32'(almost_full), 32'd1);
    check_all();
    af_thr = 5'd17;
    for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 8'(8'hA0 + i), 0, 0);
    chk("af_thr17_full", 32'(almost_full), 32'd0);
    ae_thr = 5'd20; #1;
    chk("ae_thr20_full", 32'(almost_empty), 32'd1);
    af_thr = 5'd12; ae_thr = 5'd2;

    // Random regression with phase-biased traffic.
    for (int i = 0; i < 1000; i++) begin
      logic wv, av, cv, sv, rv;
      int bias;
      bias = ((i / 64) % 2 == 0) ? 75 : 25;
      wv = ($urandom_range(0, 99) < bias);
      av = ($urandom_range(0, 99) < (100 - bias));
      cv = ($urandom_range(0, 15) == 0);
      sv = ($urandom_range(0, 79) == 0);
      rv = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) begin
        af_thr = 5'($urandom_range(0, 20));
        ae_thr = 5'($urandom_range(0, 20));
      end
      step(rv, sv, wv, 8'($urandom), av, cv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
